// File: rtl/muller_hs_tx_pkg.sv
// +----------------------------------------------------------------------+
// | muller_hs_tx_pkg: shared widths and FSM encodings for muller_hs_tx   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package muller_hs_tx_pkg;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_W   = 8;
  localparam int SENT_W          = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_REQ_HI = 2'd2;
  localparam logic [1:0] ST_REQ_LO = 2'd3;

  function automatic logic is_wait_state(input logic [1:0] st);
    return (st == ST_REQ_HI) || (st == ST_REQ_LO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muller_hs_tx_fifo.sv
// +----------------------------------------------------------------------+
// | muller_hs_tx_fifo: synchronous FIFO with wrap-bit pointers           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module muller_hs_tx_fifo
  import muller_hs_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/muller_hs_tx.sv
// +----------------------------------------------------------------------+
// | muller_hs_tx: FIFO-buffered 4-phase bundled-data handshake sender    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module muller_hs_tx
  import muller_hs_tx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_W   = DEF_TIMEOUT_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [SENT_W-1:0] sent_count_o
);

  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   ack_s;
  logic [1:0]             state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic                   timeout_q, timeout_d;
  logic [SENT_W-1:0]      sent_q, sent_d;
  logic                   avail_q, avail_d;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [DATA_W-1:0]      fifo_head;

  muller_hs_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .push_i      (s_valid),
    .push_data_i (s_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_i};
  assign ack_s      = ack_sync_q[SYNC_STAGES-1];

  assign wait_cnt_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + TIMEOUT_W'(1);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    sent_d     = sent_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (avail_q) begin
          data_d  = fifo_head;
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        req_d      = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_REQ_HI;
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          req_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_REQ_LO;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          sent_d  = sent_q + SENT_W'(1);
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_wait_state(state_d) && (&wait_cnt_d)) timeout_d = 1'b1;

    // FIFO availability is registered so IDLE never sees the word pushed on the same edge.
    avail_d = !fifo_empty && !pop;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_sync_q <= '0;
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      sent_q     <= '0;
      avail_q    <= 1'b0;
    end else begin
      ack_sync_q <= ack_sync_d;
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      sent_q     <= sent_d;
      avail_q    <= avail_d;
    end
  end

  assign s_ready      = !fifo_full;
  assign req_o        = req_q;
  assign data_o       = data_q;
  assign timeout_o    = timeout_q;
  assign sent_count_o = sent_q;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_muller_hs_tx.sv
// +----------------------------------------------------------------------+
// | tb_muller_hs_tx: directed self-checking bench for muller_hs_tx       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_muller_hs_tx;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       req_o;
  logic [3:0] data_o;
  logic       ack_i;
  logic       busy_o;
  logic       timeout_o;
  logic [7:0] sent_count_o;

  int         total;
  int         bad;
  int         exp_sent;
  bit         resp_en;
  int         dly;
  logic       prev_req;
  logic [3:0] prev_data;
  int         setup_viol;
  int         unstable;
  logic [3:0] got [$];

  muller_hs_tx #(
    .DATA_W      (4),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2),
    .TIMEOUT_W   (4)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .req_o        (req_o),
    .data_o       (data_o),
    .ack_i        (ack_i),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .sent_count_o (sent_count_o)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  // Pipeline model: follows req_o with ack_i three cycles later; also logs words at req rise.
  initial begin
    ack_i      = 1'b0;
    dly        = 0;
    prev_req   = 1'b0;
    prev_data  = '0;
    setup_viol = 0;
    unstable   = 0;
    forever begin
      @(negedge clk);
      if (!resp_en || rst) begin
        ack_i = 1'b0;
        dly   = 0;
      end else if (req_o !== ack_i) begin
        dly = dly + 1;
        if (dly >= 3) begin
          ack_i = req_o;
          dly   = 0;
        end
      end else begin
        dly = 0;
      end
      if (!rst) begin
        if (req_o && !prev_req) begin
          got.push_back(data_o);
          if (data_o !== prev_data) setup_viol++;
        end
        if (req_o && prev_req && (data_o !== prev_data)) unstable++;
      end
      prev_req  = rst ? 1'b0 : req_o;
      prev_data = data_o;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", req_o); end
    total++; if (data_o !== 4'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (sent_count_o !== 8'd0) begin bad++; $display("FAIL reset_sent: got %0d want 0", sent_count_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
  endtask

  task automatic test_single();
    int n;
    got.delete();
    resp_en = 1'b1;
    s_valid = 1'b1;
    s_data  = 4'hA;
    @(negedge clk);
    s_valid = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
    @(negedge clk);
    total++; if (data_o !== 4'h0) begin bad++; $display("FAIL single_data_early: got %h want 0", data_o); end
    @(negedge clk);
    total++; if (data_o !== 4'hA) begin bad++; $display("FAIL single_data_n2: got %h want a", data_o); end
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL single_req_n2: got %b want 0", req_o); end
    @(negedge clk);
    total++; if (req_o !== 1'b1) begin bad++; $display("FAIL single_req_n3: got %b want 1", req_o); end
    exp_sent = 1;
    n = 0;
    while ((sent_count_o !== 8'(exp_sent)) && n < 100) begin @(negedge clk); n++; end
    total++; if (n >= 100) begin bad++; $display("FAIL single_wait: got sent=%0d want %0d", sent_count_o, exp_sent); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy_o); end
    total++; if (got.size() !== 1 || got[0] !== 4'hA) begin bad++; $display("FAIL single_word: got n=%0d want one word a", got.size()); end
    total++; if (setup_viol !== 0) begin bad++; $display("FAIL single_setup: got %0d want 0", setup_viol); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL single_stable: got %0d want 0", unstable); end
  endtask

  // Word 1 leaves the FIFO for the stalled handshake, so the fifth word fills the last
  // slot and the sixth attempt is refused.
  task automatic test_fill();
    int n;
    int order_err;
    got.delete();
    resp_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d: got %b want 1", k, s_ready); end
      s_valid = 1'b1;
      s_data  = 4'(k);
      @(negedge clk);
    end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got %b want 0", s_ready); end
    s_data = 4'h6;
    @(negedge clk);
    s_valid = 1'b0;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_reject: got %b want 0", s_ready); end
    resp_en = 1'b1;
    exp_sent = exp_sent + 5;
    n = 0;
    while ((busy_o !== 1'b0 || sent_count_o !== 8'(exp_sent)) && n < 400) begin @(negedge clk); n++; end
    total++; if (n >= 400) begin bad++; $display("FAIL fill_wait: got sent=%0d want %0d", sent_count_o, exp_sent); end
    order_err = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 4'(i + 1)) order_err++;
    total++; if (got.size() !== 5) begin bad++; $display("FAIL fill_count: got %0d want 5", got.size()); end
    total++; if (order_err !== 0) begin bad++; $display("FAIL fill_order: got %0d errors want 0", order_err); end
    total++; if (unstable !== 0 || setup_viol !== 0) begin bad++; $display("FAIL fill_stable: got %0d/%0d want 0/0", unstable, setup_viol); end
  endtask

  task automatic test_timeout();
    int n;
    got.delete();
    resp_en = 1'b0;
    s_valid = 1'b1;
    s_data  = 4'h7;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (req_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL to_req_wait: got req=%b want 1", req_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_start: got %b want 0", timeout_o); end
    repeat (14) @(negedge clk);
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_14: got %b want 0", timeout_o); end
    @(negedge clk);
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_15: got %b want 1", timeout_o); end
    total++; if (req_o !== 1'b1) begin bad++; $display("FAIL to_req_held: got %b want 1", req_o); end
    resp_en = 1'b1;
    exp_sent = exp_sent + 1;
    n = 0;
    while ((busy_o !== 1'b0 || sent_count_o !== 8'(exp_sent)) && n < 100) begin @(negedge clk); n++; end
    total++; if (n >= 100) begin bad++; $display("FAIL to_late_ack: got sent=%0d want %0d", sent_count_o, exp_sent); end
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
    total++; if (got.size() !== 1 || got[0] !== 4'h7) begin bad++; $display("FAIL to_word: got n=%0d want one word 7", got.size()); end
  endtask

  task automatic test_reset_midop();
    int n;
    resp_en = 1'b0;
    s_valid = 1'b1;
    s_data  = 4'h8;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (req_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL mid_req_wait: got req=%b want 1", req_o); end
    s_valid = 1'b1;
    s_data  = 4'h9;
    @(negedge clk);
    s_data  = 4'hB;
    @(negedge clk);
    s_valid = 1'b0;
    total++; if (busy_o !== 1'b1 || req_o !== 1'b1) begin bad++; $display("FAIL mid_pre: got busy=%b req=%b want 1 1", busy_o, req_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", req_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy_o); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", s_ready); end
    total++; if (sent_count_o !== 8'd0 || timeout_o !== 1'b0) begin bad++; $display("FAIL mid_regs: got sent=%0d to=%b want 0 0", sent_count_o, timeout_o); end
    exp_sent = 0;
    repeat (6) @(negedge clk);
    total++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL mid_flushed: got req=%b busy=%b want 0 0", req_o, busy_o); end
  endtask

  task automatic test_wrap();
    int pushed;
    int cyc;
    int n;
    int order_err;
    bit saw_255;
    got.delete();
    resp_en = 1'b1;
    pushed  = 0;
    cyc     = 0;
    saw_255 = 1'b0;
    while (pushed < 256 && cyc < 20000) begin
      if (sent_count_o === 8'd255) saw_255 = 1'b1;
      if (s_ready) begin
        s_valid = 1'b1;
        s_data  = 4'(pushed);
        pushed++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    total++; if (cyc >= 20000) begin bad++; $display("FAIL wrap_push: got %0d pushed want 256", pushed); end
    n = 0;
    while ((got.size() < 256 || busy_o !== 1'b0) && n < 20000) begin
      if (sent_count_o === 8'd255) saw_255 = 1'b1;
      @(negedge clk);
      n++;
    end
    total++; if (n >= 20000) begin bad++; $display("FAIL wrap_drain: got %0d words want 256", got.size()); end
    total++; if (saw_255 !== 1'b1) begin bad++; $display("FAIL wrap_255: got %b want 1", saw_255); end
    total++; if (sent_count_o !== 8'd0) begin bad++; $display("FAIL wrap_sent: got %0d want 0", sent_count_o); end
    order_err = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 4'(i)) order_err++;
    total++; if (got.size() !== 256) begin bad++; $display("FAIL wrap_count: got %0d want 256", got.size()); end
    total++; if (order_err !== 0) begin bad++; $display("FAIL wrap_order: got %0d errors want 0", order_err); end
    total++; if (unstable !== 0 || setup_viol !== 0) begin bad++; $display("FAIL wrap_stable: got %0d/%0d want 0/0", unstable, setup_viol); end
  endtask

  initial begin
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    resp_en  = 1'b0;
    total    = 0;
    bad      = 0;
    exp_sent = 0;
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_reset_midop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
